// File: rtl/barker_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | barker_pkg : shared Barker-11 constants, FSM state and hold-register types   |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
package barker_pkg;

  localparam logic [10:0] BARKER_CODE = 11'b11100010010;
  localparam int unsigned BARKER_LEN  = 11;
  localparam logic [3:0]  c_LAST_CHIP = 4'(BARKER_LEN - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    WAIT     = 2'd3
  } state_t;

  typedef struct packed {
    logic data;
    logic last;
  } hold_t;

  // Chips go out MSB first, so chip index 0 maps to code bit 10.
  function automatic logic code_chip(input logic [3:0] idx);
    return BARKER_CODE[c_LAST_CHIP - idx];
  endfunction

endpackage
`default_nettype wire

// File: rtl/barker_chip_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | barker_chip_gen : chip counter and code lookup for the Barker-11 spreader   |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module barker_chip_gen
  import barker_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_valid,
  input  logic i_ready,
  output logic o_adv,
  output logic o_last_chip,
  output logic o_nxt_code,
  output logic o_nxt_last
);

  logic [3:0] r_chip;
  logic [3:0] w_nxt;

  assign o_adv       = i_valid & i_ready;
  assign o_last_chip = (r_chip == c_LAST_CHIP);

  // r_chip is the index of the chip currently on the output; w_nxt is the one to load next.
  always_comb begin
    w_nxt = r_chip;
    if (i_clr) begin
      w_nxt = '0;
    end else if (o_adv) begin
      w_nxt = o_last_chip ? 4'd0 : r_chip + 4'd1;
    end
  end

  assign o_nxt_code = code_chip(w_nxt);
  assign o_nxt_last = (w_nxt == c_LAST_CHIP);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_chip <= '0;
    end else begin
      r_chip <= w_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/barker_spreader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | barker_spreader : AXI-Stream Barker-11 spreader, 11 chips per input bit     |
// | Optional preamble symbols per frame with BARKER_PREAMBLE_EN. Rev 1.0        |
// +----------------------------------------------------------------------------+
module barker_spreader
  import barker_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic s_tdata,
  input  logic s_tvalid,
  input  logic s_tlast,
  output logic s_tready,
  output logic m_tdata,
  output logic m_tvalid,
  output logic m_tlast,
  output logic m_tuser,
  input  logic m_tready
);

  state_t r_state;
  hold_t  r_hold;
  logic   r_m_tdata;
  logic   r_m_tvalid;
  logic   r_m_tlast;
  logic   r_m_tuser;

  logic   w_adv;
  logic   w_last_chip;
  logic   w_nxt_code;
  logic   w_nxt_last;
  logic   w_s_tready;
  logic   w_s_hs;
  logic   w_clr;
  logic   w_data_bit;
  logic   w_data_last;
  logic   w_data_chip;

`ifdef BARKER_PREAMBLE_EN
  localparam logic [3:0] c_PRE_LAST = 4'(PREAMBLE_LEN - 1);
  logic [3:0] r_pre_cnt;
`endif

  if (PREAMBLE_LEN < 1 || PREAMBLE_LEN > 15) begin : g_bad_preamble_len
    $error("barker_spreader: PREAMBLE_LEN must be in 1..15");
  end

  barker_chip_gen u_chip_gen (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clr       (w_clr),
    .i_valid     (r_m_tvalid),
    .i_ready     (m_tready),
    .o_adv       (w_adv),
    .o_last_chip (w_last_chip),
    .o_nxt_code  (w_nxt_code),
    .o_nxt_last  (w_nxt_last)
  );

  assign w_s_tready = ~i_rst & ((r_state == IDLE) | (r_state == WAIT) |
                      ((r_state == DATA) & w_last_chip & w_adv & ~r_hold.last));
  assign w_s_hs     = s_tvalid & w_s_tready;
  assign w_clr      = w_s_hs & ((r_state == IDLE) | (r_state == WAIT));

  // A back-to-back bit feeds the output register directly so no bubble appears.
  assign w_data_bit  = (r_state == DATA && w_s_hs) ? s_tdata : r_hold.data;
  assign w_data_last = (r_state == DATA && w_s_hs) ? s_tlast : r_hold.last;
  assign w_data_chip = ~(w_nxt_code ^ w_data_bit);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_hold     <= '0;
      r_m_tdata  <= 1'b0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_tuser  <= 1'b0;
`ifdef BARKER_PREAMBLE_EN
      r_pre_cnt  <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_s_hs) begin
            r_hold <= '{data: s_tdata, last: s_tlast};
`ifdef BARKER_PREAMBLE_EN
            r_pre_cnt <= '0;
            r_state   <= PREAMBLE;
`else
            r_state   <= DATA;
`endif
          end
        end
`ifdef BARKER_PREAMBLE_EN
        PREAMBLE: begin
          if (!r_m_tvalid || m_tready) begin
            r_m_tvalid <= 1'b1;
            r_m_tlast  <= w_nxt_last;
            r_m_tuser  <= 1'b0;
            if (r_m_tvalid && w_last_chip && r_pre_cnt == c_PRE_LAST) begin
              r_state   <= DATA;
              r_m_tdata <= w_data_chip;
            end else begin
              r_m_tdata <= w_nxt_code;
              if (r_m_tvalid && w_last_chip) begin
                r_pre_cnt <= r_pre_cnt + 4'd1;
              end
            end
          end
        end
`endif
        DATA: begin
          if (!r_m_tvalid || m_tready) begin
            if (r_m_tvalid && w_last_chip && !w_s_hs) begin
              r_m_tvalid <= 1'b0;
              r_m_tdata  <= 1'b0;
              r_m_tlast  <= 1'b0;
              r_m_tuser  <= 1'b0;
              r_state    <= r_hold.last ? IDLE : WAIT;
            end else begin
              if (w_s_hs) begin
                r_hold <= '{data: s_tdata, last: s_tlast};
              end
              r_m_tvalid <= 1'b1;
              r_m_tdata  <= w_data_chip;
              r_m_tlast  <= w_nxt_last;
              r_m_tuser  <= w_nxt_last & w_data_last;
            end
          end
        end
        WAIT: begin
          if (w_s_hs) begin
            r_hold  <= '{data: s_tdata, last: s_tlast};
            r_state <= DATA;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_tready = w_s_tready;
  assign m_tdata  = r_m_tdata;
  assign m_tvalid = r_m_tvalid;
  assign m_tlast  = r_m_tlast;
  assign m_tuser  = r_m_tuser;

endmodule
`default_nettype wire

// File: tb/tb_barker_spreader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_barker_spreader : directed self-checking bench for barker_spreader       |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module tb_barker_spreader;

  localparam logic [10:0] c_CODE = 11'b11100010010;
`ifdef BARKER_PREAMBLE_EN
  localparam int c_NPRE = 2;
`else
  localparam int c_NPRE = 0;
`endif

  logic i_clk    = 1'b0;
  logic i_rst    = 1'b1;
  logic s_tdata  = 1'b0;
  logic s_tvalid = 1'b0;
  logic s_tlast  = 1'b0;
  logic m_tready = 1'b0;
  logic s_tready;
  logic m_tdata;
  logic m_tvalid;
  logic m_tlast;
  logic m_tuser;

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  barker_spreader #(.PREAMBLE_LEN(2)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .m_tuser  (m_tuser),
    .m_tready (m_tready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drives one frame of n bits (bits[0] first) and checks every accepted chip
  // as {tdata, tlast, tuser}. gap1 holds s_tvalid low for that many cycles
  // after the first bit; stall toggles m_tready with the pattern 1,0,0,1.
  task automatic run_frame(input string tag, input int n, input logic [7:0] bits,
                           input int gap1, input bit stall, output int bubbles);
    logic [2:0]  exp_q[$];
    logic [10:0] code;
    logic [2:0]  prev;
    bit          prev_stall;
    int          sent, got, cyc, gap, hs_cyc, first_v;
    code = c_CODE;
    prev = '0;
    prev_stall = 1'b0;
    sent = 0; got = 0; cyc = 0; gap = 0; hs_cyc = -1; first_v = -1;
    bubbles = 0;
    for (int s = 0; s < c_NPRE; s++)
      for (int c = 0; c < 11; c++)
        exp_q.push_back({code[10-c], (c == 10), 1'b0});
    for (int b = 0; b < n; b++)
      for (int c = 0; c < 11; c++)
        exp_q.push_back({code[10-c] ~^ bits[b], (c == 10), (c == 10) && (b == n-1)});

    while (got < exp_q.size() && cyc < 1000) begin
      m_tready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      s_tvalid = (sent < n) && (gap == 0);
      s_tdata  = s_tvalid ? bits[sent] : 1'b0;
      s_tlast  = s_tvalid && (sent == n-1);
      #1;
      if (m_tvalid) begin
        if (first_v < 0) first_v = cyc;
        if (prev_stall) check({tag, " stall hold"}, {m_tdata, m_tlast, m_tuser}, prev);
        if (m_tready) begin
          check($sformatf("%s chip %0d", tag, got), {m_tdata, m_tlast, m_tuser}, exp_q[got]);
          got++;
        end
        prev_stall = !m_tready;
        prev = {m_tdata, m_tlast, m_tuser};
      end else begin
        if (prev_stall) check({tag, " valid dropped"}, m_tvalid, 1);
        if (first_v >= 0) bubbles++;
        prev_stall = 1'b0;
      end
      if (s_tvalid && s_tready) begin
        if (sent == 0) hs_cyc = cyc;
        sent++;
        gap = (sent == 1) ? gap1 : 0;
      end else if (gap > 0) begin
        gap--;
      end
      @(negedge i_clk);
      cyc++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    check({tag, " chips done"}, got, exp_q.size());
    check({tag, " first-chip latency"}, first_v - hs_cyc, 2);
    #1;
    check({tag, " idle after frame"}, {m_tvalid, s_tready}, 2'b01);
  endtask

  initial begin
    int bub;
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    check("reset outputs", {m_tdata, m_tvalid, m_tlast, m_tuser}, 4'b0000);
    check("reset s_tready", s_tready, 1'b0);
    i_rst = 1'b0;
    #1;
    check("idle s_tready", s_tready, 1'b1);
    @(negedge i_clk);

    run_frame("single1", 1, 8'b0000_0001, 0, 1'b0, bub);
    check("single1 bubbles", bub, 0);

    run_frame("pair01", 2, 8'b0000_0010, 0, 1'b0, bub);
    check("pair01 bubbles", bub, 0);

    run_frame("stall", 3, 8'b0000_0101, 0, 1'b1, bub);
    check("stall bubbles", bub, 0);

    run_frame("wait", 2, 8'b0000_0001, 17, 1'b0, bub);
    check("wait entered", (bub >= 5), 1);

    // Reset in the middle of a symbol: chip 5 on the output when i_rst rises.
    m_tready = 1'b1;
    s_tdata  = 1'b1;
    s_tlast  = 1'b1;
    s_tvalid = 1'b1;
    @(negedge i_clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (6 + 11 * c_NPRE) @(negedge i_clk);
    check("pre-reset chip5", {m_tvalid, m_tdata, m_tlast}, 3'b100);
    i_rst = 1'b1;
    #1;
    check("reset s_tready comb", s_tready, 1'b0);
    @(negedge i_clk);
    check("mid-reset outputs", {m_tdata, m_tvalid, m_tlast, m_tuser}, 4'b0000);
    check("mid-reset s_tready", s_tready, 1'b0);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("post-reset idle", {m_tvalid, s_tready}, 2'b01);

    run_frame("after_rst", 1, 8'b0000_0000, 0, 1'b0, bub);
    check("after_rst bubbles", bub, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
